// File: rtl/sample_conditioner.sv
// ============================================================================
// Module   : sample_conditioner
// Purpose  : Moving-average smoother, decaying peak meter and clip detector
//            for offset-binary ADC samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_conditioner #(
   parameter logic [9:0]  OFFSET     = 10'd512,
   parameter int          AVG_LOG2   = 2,
   parameter logic [15:0] PEAK_DECAY = 16'd1000,
   parameter logic [7:0]  CLIP_HOLD  = 8'd100
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic [9:0] data_in,
   input  logic       data_valid,
   output logic [9:0] data_out,
   output logic       out_valid,
   output logic [9:0] peak,
   output logic       clip
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = 10 + AVG_LOG2;
   localparam logic [SW-1:0] SUM_RST = {OFFSET, {AVG_LOG2{1'b0}}};

   logic [9:0]    hist [N];
   logic [SW-1:0] sum;
   logic          s1_valid;

   logic [9:0]    mag;
   logic [15:0]   decay_cnt;

   logic [7:0]    clip_cnt;
   logic [7:0]    clip_cnt_next;
   logic          clip_hit;

   // Stage 1: history shift and running sum. The sum is exact in SW bits,
   // so modular add/subtract never loses information.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            hist[i] <= OFFSET;
         end
         sum      <= SUM_RST;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= data_valid;
         if (data_valid) begin
            hist[0] <= data_in;
            for (int i = 1; i < N; i++) begin
               hist[i] <= hist[i-1];
            end
            sum <= sum + SW'(data_in) - SW'(hist[N-1]);
         end
      end
   end

   // Stage 2: divide by N with a plain truncating slice.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         data_out  <= OFFSET;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            data_out <= sum[SW-1:AVG_LOG2];
         end
      end
   end

   always_comb begin
      mag = 10'd0;
      if (data_out >= OFFSET) begin
         mag = data_out - OFFSET;
      end else begin
         mag = OFFSET - data_out;
      end
   end

   // Stage 3: a new maximum always wins over a pending decay step.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         peak      <= 10'd0;
         decay_cnt <= 16'd0;
      end else if (out_valid) begin
         if (mag > peak) begin
            peak      <= mag;
            decay_cnt <= 16'd0;
         end else if (decay_cnt == PEAK_DECAY - 16'd1) begin
            decay_cnt <= 16'd0;
            if (peak != 10'd0) begin
               peak <= peak - 10'd1;
            end
         end else begin
            decay_cnt <= decay_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      clip_hit      = (data_in == 10'd0) || (data_in == 10'h3FF);
      clip_cnt_next = clip_cnt;
      if (clip_hit) begin
         clip_cnt_next = CLIP_HOLD;
      end else if (clip_cnt != 8'd0) begin
         clip_cnt_next = clip_cnt - 8'd1;
      end
   end

   // clip is derived from the next count so it follows the strobe by one cycle.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         clip_cnt <= 8'd0;
         clip     <= 1'b0;
      end else if (data_valid) begin
         clip_cnt <= clip_cnt_next;
         clip     <= (clip_cnt_next != 8'd0);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sample_conditioner.sv
// ============================================================================
// Module   : tb_sample_conditioner
// Purpose  : Directed self-checking bench for sample_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_conditioner;

   logic       sysclk;
   logic       reset;
   logic [9:0] data_in;
   logic       data_valid;
   logic [9:0] data_out;
   logic       out_valid;
   logic [9:0] peak;
   logic       clip;

   int total = 0;
   int bad   = 0;

   sample_conditioner #(
      .OFFSET     (10'd512),
      .AVG_LOG2   (2),
      .PEAK_DECAY (16'd4),
      .CLIP_HOLD  (8'd3)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .peak       (peak),
      .clip       (clip)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      reset = 1'b1;
      repeat (2) @(negedge sysclk);
      reset = 1'b0;
   endtask

   // One isolated strobe; checks T+1, T+2 and T+3 observations.
   task automatic strobe_full(input string tag, input logic [9:0] val,
                              input logic [9:0] exp_out, input logic [9:0] exp_peak);
      @(negedge sysclk);
      data_in    = val;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      chk({tag, ".ov_t1"}, 16'(out_valid), 16'd0);
      @(negedge sysclk);
      chk({tag, ".ov_t2"}, 16'(out_valid), 16'd1);
      chk({tag, ".dout"}, 16'(data_out), 16'(exp_out));
      @(negedge sysclk);
      chk({tag, ".ov_t3"}, 16'(out_valid), 16'd0);
      chk({tag, ".dout_hold"}, 16'(data_out), 16'(exp_out));
      chk({tag, ".peak"}, 16'(peak), 16'(exp_peak));
   endtask

   task automatic strobe_clip(input string tag, input logic [9:0] val, input logic exp_clip);
      @(negedge sysclk);
      data_in    = val;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      chk({tag, ".t1"}, 16'(clip), 16'(exp_clip));
      repeat (3) @(negedge sysclk);
      chk({tag, ".hold"}, 16'(clip), 16'(exp_clip));
   endtask

   task automatic burst_700();
      logic [9:0] exp_b [4];
      exp_b[0] = 10'd559;
      exp_b[1] = 10'd606;
      exp_b[2] = 10'd653;
      exp_b[3] = 10'd700;
      for (int k = 0; k < 8; k++) begin
         @(negedge sysclk);
         if (k >= 2 && k < 6) begin
            chk($sformatf("b2b.ov%0d", k), 16'(out_valid), 16'd1);
            chk($sformatf("b2b.dout%0d", k), 16'(data_out), 16'(exp_b[k-2]));
         end else begin
            chk($sformatf("b2b.ov%0d", k), 16'(out_valid), 16'd0);
         end
         data_in    = 10'd700;
         data_valid = (k < 4);
      end
      data_valid = 1'b0;
   endtask

   initial begin
      logic [9:0] exp_out;
      logic [9:0] exp_peak;
      logic [9:0] step_out [4];
      logic [9:0] step_peak [4];
      logic [9:0] fall_out [4];

      reset      = 1'b1;
      data_in    = 10'd0;
      data_valid = 1'b0;

      // Reset values, stable with no strobes.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge sysclk);
         chk("rst.dout", 16'(data_out), 16'd512);
         chk("rst.ov", 16'(out_valid), 16'd0);
         chk("rst.peak", 16'(peak), 16'd0);
         chk("rst.clip", 16'(clip), 16'd0);
      end

      // Step response: 600 strobes spaced 10 cycles apart.
      step_out[0] = 10'd534; step_peak[0] = 10'd22;
      step_out[1] = 10'd556; step_peak[1] = 10'd44;
      step_out[2] = 10'd578; step_peak[2] = 10'd66;
      step_out[3] = 10'd600; step_peak[3] = 10'd88;
      for (int s = 0; s < 4; s++) begin
         strobe_full($sformatf("step%0d", s), 10'd600, step_out[s], step_peak[s]);
         repeat (6) @(negedge sysclk);
      end

      // Back-to-back strobes after reset.
      do_reset();
      burst_700();

      // Peak decay: load 188, then feed mid-scale until peak saturates at 0.
      do_reset();
      burst_700();
      @(negedge sysclk);
      chk("decay.peak188", 16'(peak), 16'd188);
      fall_out[0] = 10'd653;
      fall_out[1] = 10'd606;
      fall_out[2] = 10'd559;
      fall_out[3] = 10'd512;
      for (int k = 1; k <= 800; k++) begin
         exp_out  = (k <= 4) ? fall_out[k-1] : 10'd512;
         exp_peak = (k / 4 >= 188) ? 10'd0 : 10'(188 - k / 4);
         strobe_full($sformatf("decay%0d", k), 10'd512, exp_out, exp_peak);
      end

      // Clip hold with CLIP_HOLD=3, retriggered by a zero code.
      @(negedge sysclk);
      chk("clip.idle", 16'(clip), 16'd0);
      strobe_clip("clip1023", 10'd1023, 1'b1);
      strobe_clip("clip_a1", 10'd512, 1'b1);
      strobe_clip("clip_a2", 10'd512, 1'b1);
      strobe_clip("clip_a3", 10'd512, 1'b0);
      strobe_clip("clip0", 10'd0, 1'b1);
      strobe_clip("clip_b1", 10'd512, 1'b1);
      strobe_clip("clip_b2", 10'd512, 1'b1);
      strobe_clip("clip_b3", 10'd512, 1'b0);

      // Reset one cycle after a strobe discards it.
      @(negedge sysclk);
      data_in    = 10'd900;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      reset      = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      chk("mid.ov", 16'(out_valid), 16'd0);
      chk("mid.dout", 16'(data_out), 16'd512);
      chk("mid.peak", 16'(peak), 16'd0);
      chk("mid.clip", 16'(clip), 16'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge sysclk);
         chk("mid.no_ov", 16'(out_valid), 16'd0);
      end
      strobe_full("mid.after", 10'd512, 10'd512, 10'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
